input_port_rc: RTL

- One router input port, directly upstream of the switch arbiter and crossbar.
- Buffers incoming flits in a small FIFO and computes the XY route from each head flit.
- Holds that route for the whole packet (wormhole) and raises a request toward the arbiter until the tail flit has been granted.
- Its full output is the per-port backpressure bit the router exports on request[n].

---
 rtl/input_port_rc_if.sv | 37 +++
 rtl/input_port_rc.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/input_port_rc_if.sv
// Router input-port link bundle: upstream flit push side plus arbiter/crossbar side.
// Latency: none (wires only).
// Backpressure: full stalls the upstream sender; out_grant pops one flit while out_req is high.
// Ports:
//   in_flit/in_valid  flit and strobe from the upstream link
//   full              FIFO full, upstream must hold off
//   out_flit/out_req  head flit and arbiter request
//   out_port          latched XY route (0=L 1=N 2=E 3=W 4=S)
//   out_grant         arbiter grant, pops one flit
//   count/err         occupancy and sticky error flag
interface input_port_rc_if #(
  parameter int Width     = 8,
  parameter int Ptr_width = 2,
  parameter int Select    = 3
);
  logic [Width-1:0]   in_flit;
  logic               in_valid;
  logic               full;
  logic [Width-1:0]   out_flit;
  logic               out_req;
  logic [Select-1:0]  out_port;
  logic               out_grant;
  logic [Ptr_width:0] count;
  logic               err;

  // Drives the port: upstream link plus arbiter.
  modport master (
    output in_flit, in_valid, out_grant,
    input  full, out_flit, out_req, out_port, count, err
  );

  // The input port itself.
  modport slave (
    input  in_flit, in_valid, out_grant,
    output full, out_flit, out_req, out_port, count, err
  );
endinterface

// File: rtl/input_port_rc.sv
// Router input port: flit FIFO plus wormhole XY route computation, one request per packet.
// Latency: head pushed on edge E0 is routed on E1, out_req from after E1 (2 edges to first grant).
// Backpressure: full when Depth flits held; pushes while full are dropped and flag err.
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-low reset
//   port_if      slave side of input_port_rc_if (flit in, request/route/flit out, grant in)
module input_port_rc #(
  parameter int Width     = 8,
  parameter int Depth     = 4,
  parameter int Ptr_width = 2,
  parameter int Select    = 3,
  parameter int X_pos     = 0,
  parameter int Y_pos     = 0
) (
  input  logic            clk,
  input  logic            rst,
  input_port_rc_if.slave  port_if
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [Ptr_width:0]   FULL_CNT = (Ptr_width+1)'(Depth);
  localparam logic [Ptr_width:0]   CNT_ONE  = (Ptr_width+1)'(1);
  localparam logic [Ptr_width-1:0] PTR_ONE  = Ptr_width'(1);
  localparam logic [2:0]           X_COORD  = 3'(X_pos);
  localparam logic [2:0]           Y_COORD  = 3'(Y_pos);
  localparam logic [Select-1:0]    PORT_L   = Select'(0);
  localparam logic [Select-1:0]    PORT_N   = Select'(1);
  localparam logic [Select-1:0]    PORT_E   = Select'(2);
  localparam logic [Select-1:0]    PORT_W   = Select'(3);
  localparam logic [Select-1:0]    PORT_S   = Select'(4);

  state_t               state_q, state_d;
  logic [Width-1:0]     mem [Depth];
  logic [Ptr_width-1:0] wr_ptr_q, rd_ptr_q;
  logic [Ptr_width:0]   cnt_q;
  logic [Select-1:0]    port_q;
  logic                 err_q;
  logic                 first_pend_q;   // packet's own head flit not yet popped

  logic                 empty, full_w;
  logic [Width-1:0]     front_dat;
  logic [1:0]           front_typ;
  logic                 front_is_head, front_is_last;
  logic                 push_vld, drop_vld, pop_vld;
  logic                 req_vld, discard_vld, latch_route, stray_head, err_set;
  logic [Select-1:0]    route_dat;

  // XY dimension-order routing: resolve X first, then Y.
  function automatic logic [Select-1:0] xy_route(input logic [2:0] dst_x, input logic [2:0] dst_y);
    if (dst_x > X_COORD)      return PORT_E;
    else if (dst_x < X_COORD) return PORT_W;
    else if (dst_y > Y_COORD) return PORT_N;
    else if (dst_y < Y_COORD) return PORT_S;
    else                      return PORT_L;
  endfunction

  assign empty         = (cnt_q == '0);
  assign full_w        = (cnt_q == FULL_CNT);
  assign front_dat     = mem[rd_ptr_q];
  assign front_typ     = front_dat[7:6];
  assign front_is_head = front_typ[0];   // 01 head, 11 head+tail
  assign front_is_last = front_typ[1];   // 10 tail, 11 head+tail
  assign route_dat     = xy_route(front_dat[5:3], front_dat[2:0]);

  // full is judged on the registered count, so a same-cycle pop never frees room for a push.
  assign push_vld = port_if.in_valid && !full_w;
  assign drop_vld = port_if.in_valid && full_w;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty && front_is_head) state_d = ACTIVE;
      ACTIVE:  if (pop_vld && front_is_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/control logic.
  always_comb begin
    req_vld     = 1'b0;
    discard_vld = 1'b0;
    latch_route = 1'b0;
    stray_head  = 1'b0;
    case (state_q)
      IDLE: begin
        latch_route = !empty && front_is_head;
        discard_vld = !empty && !front_is_head;   // orphan body/tail
      end
      ACTIVE: begin
        req_vld    = !empty;
        // A second head inside a packet is forwarded as-is but flagged.
        stray_head = !empty && front_is_head && !first_pend_q;
      end
      default: ;
    endcase
    pop_vld = discard_vld || (req_vld && port_if.out_grant);
    err_set = drop_vld || discard_vld || stray_head;
  end

  // Storage has no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_vld) mem[wr_ptr_q] <= port_if.in_flit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      port_q       <= '0;
      err_q        <= 1'b0;
      first_pend_q <= 1'b0;
    end else begin
      if (push_vld) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_vld)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (push_vld && !pop_vld)      cnt_q <= cnt_q + CNT_ONE;
      else if (pop_vld && !push_vld) cnt_q <= cnt_q - CNT_ONE;
      if (latch_route) port_q <= route_dat;
      if (err_set)     err_q  <= 1'b1;
      if (latch_route)                         first_pend_q <= 1'b1;
      else if (req_vld && port_if.out_grant)   first_pend_q <= 1'b0;
    end
  end

  assign port_if.full     = full_w;
  assign port_if.out_flit = empty ? '0 : front_dat;
  assign port_if.out_req  = req_vld;
  assign port_if.out_port = port_q;
  assign port_if.count    = cnt_q;
  assign port_if.err      = err_q;

endmodule
